// File: rtl/bcd_entry_monitor_pkg.sv
// rtl/bcd_entry_monitor_pkg.sv - display codes, FSM states and page indices for the BCD entry monitor
package bcd_entry_monitor_pkg;

   localparam logic [3:0] DISP_OFF = 4'hF;
   localparam logic [3:0] DISP_NEG = 4'hA;

   typedef enum logic [1:0] {
      ST_ENTRY = 2'd0,
      ST_CALC  = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   localparam logic [1:0] PAGE_VALUE  = 2'd0;
   localparam logic [1:0] PAGE_BLANK0 = 2'd1;
   localparam logic [1:0] PAGE_DELTA  = 2'd2;
   localparam logic [1:0] PAGE_BLANK1 = 2'd3;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - one-digit BCD adder/subtractor with carry/borrow chain
module bcd_digit_addsub (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       sub_i,
   input  logic       carry_i,
   output logic [3:0] sum_o,
   output logic       carry_o
);

   logic [4:0] raw;

   // Binary add/sub followed by decimal correction (+6 on carry, +10 on borrow)
   always_comb begin
      raw     = 5'd0;
      sum_o   = 4'd0;
      carry_o = 1'b0;
      if (sub_i) begin
         raw     = {1'b0, a_i} - {1'b0, b_i} - {4'd0, carry_i};
         carry_o = raw[4];
         sum_o   = raw[4] ? raw[3:0] + 4'd10 : raw[3:0];
      end else begin
         raw     = {1'b0, a_i} + {1'b0, b_i} + {4'd0, carry_i};
         carry_o = raw > 5'd9;
         sum_o   = carry_o ? raw[3:0] + 4'd6 : raw[3:0];
      end
   end

endmodule

// File: rtl/bcd_entry_monitor.sv
// rtl/bcd_entry_monitor.sv - N-digit signed BCD entry, serial delta and display page sequencer
module bcd_entry_monitor
   import bcd_entry_monitor_pkg::*;
#(
   parameter int DIGITS    = 3,
   parameter int BLINK_DIV = 25_000_000,
   parameter int PAGE_DIV  = 50_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    digit_in,
   input  logic                          enter,
   input  logic                          sign_in,
   output logic [4*DIGITS-1:0]           value_bcd,
   output logic                          value_neg,
   output logic [4*DIGITS-1:0]           delta_bcd,
   output logic                          delta_neg,
   output logic                          delta_ovf,
   output logic                          delta_valid,
   output logic                          digit_err,
   output logic [$clog2(DIGITS+1)-1:0]   entry_idx,
   output logic [4*(DIGITS+1)-1:0]       disp_code,
   output logic [DIGITS:0]               disp_en
);

   localparam int IDXW = $clog2(DIGITS + 1);
   localparam int MW   = 4 * DIGITS;
   localparam int DW   = 4 * (DIGITS + 1);
   localparam int BW   = $clog2(BLINK_DIV + 1);
   localparam int PW   = $clog2(PAGE_DIV + 1);
   localparam logic [IDXW-1:0] LAST_POS   = IDXW'(DIGITS - 1);
   localparam logic [IDXW-1:0] DONE_POS   = IDXW'(DIGITS);
   localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [PW-1:0]   PAGE_LAST  = PW'(PAGE_DIV - 1);
   localparam logic [MW-1:0]   ALL_NINES  = {DIGITS{4'h9}};
   localparam logic [DW-1:0]   ALL_OFF    = {(DIGITS+1){DISP_OFF}};

   state_e           state_q, state_d;
   logic             enter_q;
   logic [MW-1:0]    entry_q, new_mag;
   logic [IDXW-1:0]  idx_q, cap_pos, calc_idx_q;
   logic [MW-1:0]    value_q, prev_q, res_q, delta_q;
   logic             value_neg_q, prev_neg_q, delta_neg_q, delta_ovf_q;
   logic             delta_valid_q, digit_err_q, carry_q;
   logic [BW-1:0]    blink_cnt_q;
   logic             blink_q;
   logic [PW-1:0]    page_cnt_q;
   logic [1:0]       page_q;
   logic [DW-1:0]    disp_code_q, disp_code_d;
   logic [DIGITS:0]  disp_en_q, disp_en_d;
   logic             rise, accept, capture, last_cap, calc_done, calc_step, calc_finish;
   logic             add_mode, new_gt, ovf, neg_raw;
   logic [MW-1:0]    op_a, op_b, mag_next;
   logic [3:0]       a_dig, b_dig, sum_dig;
   logic             carry_dig;

   assign rise      = enter & ~enter_q;
   assign calc_done = (calc_idx_q == DONE_POS);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_ENTRY;
      else      state_q <= state_d;
   end

   // Next-state: the last digit always goes to CALC, a first digit from SHOW reopens ENTRY
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ENTRY: if (last_cap) state_d = ST_CALC;
         ST_CALC:  if (calc_done) state_d = ST_SHOW;
         ST_SHOW:  begin
            if (last_cap)     state_d = ST_CALC;
            else if (capture) state_d = ST_ENTRY;
         end
         default:  state_d = ST_ENTRY;
      endcase
   end

   // FSM output decode: capture strobes and CALC step/finish strobes
   always_comb begin
      accept      = rise && (state_q != ST_CALC);
      capture     = accept && is_bcd(digit_in);
      cap_pos     = (state_q == ST_SHOW) ? '0 : idx_q;
      last_cap    = capture && (cap_pos == LAST_POS);
      calc_step   = (state_q == ST_CALC) && !calc_done;
      calc_finish = (state_q == ST_CALC) && calc_done;
   end

   // Entry word with the candidate digit dropped into its slot
   always_comb begin
      new_mag = (state_q == ST_SHOW) ? '0 : entry_q;
      for (int i = 0; i < DIGITS; i++)
         if (cap_pos == IDXW'(i)) new_mag[4*i +: 4] = digit_in;
   end

   // Capture digits; on the final digit shift value into previous and normalise -0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enter_q     <= 1'b0;
         entry_q     <= '0;
         idx_q       <= '0;
         value_q     <= '0;
         value_neg_q <= 1'b0;
         prev_q      <= '0;
         prev_neg_q  <= 1'b0;
         digit_err_q <= 1'b0;
      end else begin
         enter_q     <= enter;
         digit_err_q <= accept && !is_bcd(digit_in);
         if (capture) begin
            entry_q <= new_mag;
            if (last_cap) begin
               idx_q       <= '0;
               prev_q      <= value_q;
               prev_neg_q  <= value_neg_q;
               value_q     <= new_mag;
               value_neg_q <= sign_in && (new_mag != '0);
            end else begin
               idx_q <= cap_pos + 1'b1;
            end
         end
      end
   end

   // Operand ordering: add magnitudes on differing signs, else larger minus smaller
   always_comb begin
      add_mode = value_neg_q != prev_neg_q;
      new_gt   = value_q > prev_q;
      op_a     = (add_mode || new_gt) ? value_q : prev_q;
      op_b     = (add_mode || new_gt) ? prev_q : value_q;
      neg_raw  = (add_mode || new_gt) ? value_neg_q : ~value_neg_q;
      ovf      = add_mode && carry_q;
      mag_next = ovf ? ALL_NINES : res_q;
      a_dig    = 4'd0;
      b_dig    = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (calc_idx_q == IDXW'(i)) begin
            a_dig = op_a[4*i +: 4];
            b_dig = op_b[4*i +: 4];
         end
      end
   end

   bcd_digit_addsub u_addsub (
      .a_i     (a_dig),
      .b_i     (b_dig),
      .sub_i   (~add_mode),
      .carry_i (carry_q),
      .sum_o   (sum_dig),
      .carry_o (carry_dig)
   );

   // Serial LSD-first delta, then one finishing cycle that saturates, signs and publishes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         calc_idx_q    <= '0;
         carry_q       <= 1'b0;
         res_q         <= '0;
         delta_q       <= '0;
         delta_neg_q   <= 1'b0;
         delta_ovf_q   <= 1'b0;
         delta_valid_q <= 1'b0;
      end else begin
         delta_valid_q <= calc_finish;
         if (state_q != ST_CALC) begin
            calc_idx_q <= '0;
            carry_q    <= 1'b0;
         end else if (calc_step) begin
            for (int i = 0; i < DIGITS; i++)
               if (calc_idx_q == IDXW'(i)) res_q[4*i +: 4] <= sum_dig;
            carry_q    <= carry_dig;
            calc_idx_q <= calc_idx_q + 1'b1;
         end
         if (calc_finish) begin
            delta_q     <= mag_next;
            delta_ovf_q <= ovf;
            delta_neg_q <= (mag_next != '0) && neg_raw;
         end
      end
   end

   // Free-running blink divider and page divider that restarts whenever SHOW is entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
         page_cnt_q  <= '0;
         page_q      <= PAGE_VALUE;
      end else begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
         if (state_q != ST_SHOW) begin
            page_cnt_q <= '0;
            page_q     <= PAGE_VALUE;
         end else if (page_cnt_q == PAGE_LAST) begin
            page_cnt_q <= '0;
            page_q     <= page_q + 2'd1;
         end else begin
            page_cnt_q <= page_cnt_q + 1'b1;
         end
      end
   end

   // Display composition: entry view with blinking cursor, or the rotating SHOW pages
   always_comb begin
      disp_code_d = ALL_OFF;
      disp_en_d   = '1;
      case (state_q)
         ST_ENTRY: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (IDXW'(i) < idx_q) begin
                  disp_code_d[4*i +: 4] = entry_q[4*i +: 4];
               end else if (IDXW'(i) == idx_q) begin
                  disp_code_d[4*i +: 4] = digit_in;
                  disp_en_d[i]          = blink_q;
               end
            end
            disp_code_d[DW-1 -: 4] = sign_in ? DISP_NEG : DISP_OFF;
         end
         ST_SHOW: begin
            case (page_q)
               PAGE_VALUE: disp_code_d = {value_neg_q ? DISP_NEG : DISP_OFF, value_q};
               PAGE_DELTA: disp_code_d = {delta_neg_q ? DISP_NEG : DISP_OFF, delta_q};
               PAGE_BLANK0, PAGE_BLANK1: disp_code_d = ALL_OFF;
               default:    disp_code_d = ALL_OFF;
            endcase
         end
         default: disp_code_d = ALL_OFF;
      endcase
   end

   // Registered display so reset shows all positions off and enabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_code_q <= ALL_OFF;
         disp_en_q   <= '1;
      end else begin
         disp_code_q <= disp_code_d;
         disp_en_q   <= disp_en_d;
      end
   end

   assign value_bcd   = value_q;
   assign value_neg   = value_neg_q;
   assign delta_bcd   = delta_q;
   assign delta_neg   = delta_neg_q;
   assign delta_ovf   = delta_ovf_q;
   assign delta_valid = delta_valid_q;
   assign digit_err   = digit_err_q;
   assign entry_idx   = idx_q;
   assign disp_code   = disp_code_q;
   assign disp_en     = disp_en_q;

endmodule

// File: tb/tb_bcd_entry_monitor.sv
// tb/tb_bcd_entry_monitor.sv - randomized self-checking bench for bcd_entry_monitor
module tb_bcd_entry_monitor;

   localparam int D   = 3;
   localparam int W   = 4 * D;
   localparam int DW  = 4 * (D + 1);
   localparam int MAX = 999;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    digit_in;
   logic          enter;
   logic          sign_in;
   logic [W-1:0]  value_bcd, delta_bcd;
   logic          value_neg, delta_neg, delta_ovf, delta_valid, digit_err;
   logic [1:0]    entry_idx;
   logic [DW-1:0] disp_code;
   logic [D:0]    disp_en;

   int n_tests = 0;
   int n_fail  = 0;
   int model_prev = 0;

   always #5 clk = ~clk;

   bcd_entry_monitor #(.DIGITS(D), .BLINK_DIV(4), .PAGE_DIV(8)) dut (
      .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .sign_in(sign_in),
      .value_bcd(value_bcd), .value_neg(value_neg), .delta_bcd(delta_bcd),
      .delta_neg(delta_neg), .delta_ovf(delta_ovf), .delta_valid(delta_valid),
      .digit_err(digit_err), .entry_idx(entry_idx), .disp_code(disp_code), .disp_en(disp_en)
   );

   function automatic logic [W-1:0] to_bcd(input int m);
      logic [W-1:0] r;
      int v = m;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] page_of(input int v);
      int a = (v < 0) ? -v : v;
      return {(v < 0) ? 4'hA : 4'hF, to_bcd(a)};
   endfunction

   function automatic int clamp_abs(input int v);
      int a = (v < 0) ? -v : v;
      return (a > MAX) ? MAX : a;
   endfunction

   task automatic press(input logic [3:0] d, input int hold);
      digit_in = d;
      enter = 1'b1;
      repeat (hold) @(negedge clk);
      enter = 1'b0;
      @(negedge clk);
   endtask

   task automatic enter_number(input int mag, input bit neg, output int first_k, output int n_high);
      int pw = 1;
      first_k = 0;
      n_high = 0;
      for (int i = 0; i < D - 1; i++) begin
         press(4'((mag / pw) % 10), 1);
         pw = pw * 10;
      end
      digit_in = 4'((mag / pw) % 10);
      sign_in = neg;
      enter = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) enter = 1'b0;
         if (delta_valid) begin
            n_high++;
            if (first_k == 0) first_k = k;
         end
      end
      sign_in = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (value_bcd !== '0)   begin n_fail++; $display("FAIL reset value_bcd: got %h, expected 0", value_bcd); end
      n_tests++; if (value_neg !== 1'b0) begin n_fail++; $display("FAIL reset value_neg: got %b, expected 0", value_neg); end
      n_tests++; if (delta_bcd !== '0)   begin n_fail++; $display("FAIL reset delta_bcd: got %h, expected 0", delta_bcd); end
      n_tests++; if ({delta_neg, delta_ovf, delta_valid, digit_err} !== 4'b0)
                    begin n_fail++; $display("FAIL reset flags: got %b, expected 0000", {delta_neg, delta_ovf, delta_valid, digit_err}); end
      n_tests++; if (entry_idx !== 2'd0) begin n_fail++; $display("FAIL reset entry_idx: got %0d, expected 0", entry_idx); end
      n_tests++; if (disp_code !== 16'hFFFF) begin n_fail++; $display("FAIL reset disp_code: got %h, expected ffff", disp_code); end
      n_tests++; if (disp_en !== 4'hF)   begin n_fail++; $display("FAIL reset disp_en: got %b, expected 1111", disp_en); end
      rst = 1'b1;
      @(negedge clk);
      model_prev = 0;
   endtask

   task automatic test_entries;
      int tbl_mag[8] = '{125, 130, 120, 125, 250, 999, 999, 0};
      bit tbl_neg[8] = '{0, 0, 0, 0, 1, 0, 1, 1};
      int mag, newv, d, fk, nh;
      bit neg;
      for (int it = 0; it < 20; it++) begin
         if (it < 8) begin
            mag = tbl_mag[it];
            neg = tbl_neg[it];
         end else begin
            mag = (it % 5 == 0) ? MAX : int'($urandom_range(0, MAX));
            neg = 1'($urandom_range(0, 1));
         end
         enter_number(mag, neg, fk, nh);
         newv = neg ? -mag : mag;
         d = newv - model_prev;
         n_tests++; if (value_bcd !== to_bcd(mag)) begin n_fail++; $display("FAIL entry%0d value_bcd: got %h, expected %h", it, value_bcd, to_bcd(mag)); end
         n_tests++; if (value_neg !== (newv < 0)) begin n_fail++; $display("FAIL entry%0d value_neg: got %b, expected %b", it, value_neg, newv < 0); end
         n_tests++; if (delta_bcd !== to_bcd(clamp_abs(d))) begin n_fail++; $display("FAIL entry%0d delta_bcd: got %h, expected %h", it, delta_bcd, to_bcd(clamp_abs(d))); end
         n_tests++; if (delta_neg !== (d < 0)) begin n_fail++; $display("FAIL entry%0d delta_neg: got %b, expected %b", it, delta_neg, d < 0); end
         n_tests++; if (delta_ovf !== (d > MAX || d < -MAX)) begin n_fail++; $display("FAIL entry%0d delta_ovf: got %b, expected %b", it, delta_ovf, d > MAX || d < -MAX); end
         n_tests++; if (fk != D + 2) begin n_fail++; $display("FAIL entry%0d delta_valid timing: got sample %0d, expected %0d", it, fk, D + 2); end
         n_tests++; if (nh != 1) begin n_fail++; $display("FAIL entry%0d delta_valid width: got %0d, expected 1", it, nh); end
         model_prev = newv;
      end
   endtask

   task automatic test_digit_err_and_hold;
      int errs;
      for (int rep = 0; rep < 2; rep++) begin
         digit_in = 4'hC;
         enter = 1'b1;
         errs = 0;
         for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) enter = 1'b0;
            if (digit_err) errs++;
         end
         n_tests++; if (errs != 1) begin n_fail++; $display("FAIL digit_err pulse%0d: got %0d cycles, expected 1", rep, errs); end
         n_tests++; if (entry_idx !== 2'(rep)) begin n_fail++; $display("FAIL digit_err idx%0d: got %0d, expected %0d", rep, entry_idx, rep); end
         if (rep == 0) press(4'd3, 1);
      end
      press(4'd2, 20);
      n_tests++; if (entry_idx !== 2'd2) begin n_fail++; $display("FAIL enter held: got idx %0d, expected 2", entry_idx); end
      press(4'd1, 1);
      repeat (6) @(negedge clk);
      n_tests++; if (value_bcd !== 12'h123) begin n_fail++; $display("FAIL held entry value: got %h, expected 123", value_bcd); end
      n_tests++; if (entry_idx !== 2'd0) begin n_fail++; $display("FAIL held entry idx: got %0d, expected 0", entry_idx); end
      model_prev = 123;
   endtask

   task automatic test_display;
      logic prev_en;
      int tr, fk, newv;
      press(4'd4, 1);
      digit_in = 4'd6;
      sign_in = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++; if (disp_code !== 16'hAF64) begin n_fail++; $display("FAIL entry disp_code: got %h, expected af64", disp_code); end
      n_tests++; if ({disp_en[3:2], disp_en[0]} !== 3'b111) begin n_fail++; $display("FAIL entry disp_en: got %b, expected 11x1", disp_en); end
      tr = 0;
      prev_en = disp_en[1];
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (disp_en[1] !== prev_en) tr++;
         prev_en = disp_en[1];
      end
      n_tests++; if (tr != 4) begin n_fail++; $display("FAIL blink toggles: got %0d, expected 4", tr); end
      press(4'd6, 1);
      digit_in = 4'd7;
      enter = 1'b1;
      fk = 0;
      newv = -764;
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         if (k == 1) enter = 1'b0;
         if (delta_valid && fk == 0) fk = k;
         if (k == 9 || k == 41) begin
            n_tests++; if (disp_code !== page_of(newv)) begin n_fail++; $display("FAIL page0 @%0d: got %h, expected %h", k, disp_code, page_of(newv)); end
            n_tests++; if (disp_en !== 4'hF) begin n_fail++; $display("FAIL page0 en @%0d: got %b, expected 1111", k, disp_en); end
         end
         if (k == 17 || k == 33) begin
            n_tests++; if (disp_code !== 16'hFFFF) begin n_fail++; $display("FAIL blank page @%0d: got %h, expected ffff", k, disp_code); end
         end
         if (k == 25) begin
            n_tests++; if (disp_code !== page_of(newv - model_prev)) begin n_fail++; $display("FAIL delta page: got %h, expected %h", disp_code, page_of(newv - model_prev)); end
         end
      end
      n_tests++; if (fk != D + 2) begin n_fail++; $display("FAIL display delta_valid timing: got %0d, expected %0d", fk, D + 2); end
      sign_in = 1'b0;
      model_prev = newv;
   endtask

   task automatic test_calc_ignores_enter;
      int fk;
      press(4'd1, 1);
      press(4'd1, 1);
      digit_in = 4'd1;
      enter = 1'b1;
      fk = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) enter = 1'b0;
         if (k == 2) begin digit_in = 4'd5; enter = 1'b1; end
         if (k == 3) enter = 1'b0;
         if (delta_valid && fk == 0) fk = k;
      end
      n_tests++; if (entry_idx !== 2'd0) begin n_fail++; $display("FAIL calc enter ignored idx: got %0d, expected 0", entry_idx); end
      n_tests++; if (value_bcd !== 12'h111) begin n_fail++; $display("FAIL calc enter value: got %h, expected 111", value_bcd); end
      n_tests++; if (delta_bcd !== to_bcd(clamp_abs(111 - model_prev))) begin n_fail++; $display("FAIL calc enter delta: got %h, expected %h", delta_bcd, to_bcd(clamp_abs(111 - model_prev))); end
      n_tests++; if (fk != D + 2) begin n_fail++; $display("FAIL calc enter timing: got %0d, expected %0d", fk, D + 2); end
      model_prev = 111;
   endtask

   task automatic test_reset_mid_entry;
      int fk, nh;
      press(4'd2, 1);
      press(4'd3, 1);
      n_tests++; if (entry_idx !== 2'd2) begin n_fail++; $display("FAIL mid entry idx: got %0d, expected 2", entry_idx); end
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if ({value_bcd, delta_bcd} !== '0) begin n_fail++; $display("FAIL mid reset values: got %h %h, expected 0 0", value_bcd, delta_bcd); end
      n_tests++; if (entry_idx !== 2'd0) begin n_fail++; $display("FAIL mid reset idx: got %0d, expected 0", entry_idx); end
      n_tests++; if ({disp_code, disp_en} !== 20'hFFFFF) begin n_fail++; $display("FAIL mid reset display: got %h %b, expected ffff 1111", disp_code, disp_en); end
      rst = 1'b1;
      @(negedge clk);
      model_prev = 0;
      enter_number(7, 1'b0, fk, nh);
      n_tests++; if (value_bcd !== 12'h007) begin n_fail++; $display("FAIL after reset value: got %h, expected 007", value_bcd); end
      n_tests++; if ({delta_bcd, delta_neg, delta_ovf} !== {12'h007, 2'b00}) begin n_fail++; $display("FAIL after reset delta: got %h %b %b, expected 007 0 0", delta_bcd, delta_neg, delta_ovf); end
      n_tests++; if (fk != D + 2 || nh != 1) begin n_fail++; $display("FAIL after reset valid: got at %0d x%0d, expected %0d x1", fk, nh, D + 2); end
   endtask

   initial begin
      rst = 1'b0;
      enter = 1'b0;
      digit_in = 4'd0;
      sign_in = 1'b0;
      test_reset();
      test_entries();
      test_digit_err_and_hold();
      test_display();
      test_calc_ignores_enter();
      test_reset_mid_entry();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
